// File: rtl/spm_arbiter.sv
// spm_arbiter: shares one serial-parallel multiplier core between NREQ requesters.
// A round-robin arbiter accepts one operand pair in IDLE and sequences the core
// (start pulse, wait for done). It returns the product, or a watchdog error, over
// a per-requester valid/ready response channel.
module spm_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 128,
    parameter int TW      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_mc,
    input  logic [32*NREQ-1:0]   req_mp,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [63:0]          resp_prod,
    output logic                 resp_err,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic [31:0]          mul_mc,
    output logic [31:0]          mul_mp,
    output logic                 mul_start,
    input  logic [63:0]          mul_prod,
    input  logic                 mul_done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr;
    logic [TW-1:0]  wd;
    logic [IDW-1:0] gnt;
    logic           gnt_vld;
    logic [31:0]    sel_mc;
    logic [31:0]    sel_mp;
    logic           wd_expired;

    assign wd_expired = (wd == TW'(TIMEOUT - 1));

    // Round-robin pick: first valid at or above rr, then wrap to those below rr.
    // NOTE: every variable written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        sel_mc  = '0;
        sel_mp  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld && req_valid[i] && (IDW'(i) >= rr)) begin
                gnt     = IDW'(i);
                gnt_vld = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld && req_valid[i] && (IDW'(i) < rr)) begin
                gnt     = IDW'(i);
                gnt_vld = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                sel_mc = req_mc[32*i +: 32];
                sel_mp = req_mp[32*i +: 32];
            end
        end
    end

    // Handshake outputs decoded from state. req_ready is masked while rst is high
    // because it is the only output that does not come from a register.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (state == IDLE && gnt_vld && !rst) begin
            req_ready[gnt] = 1'b1;
        end
        if (state == RESP) begin
            resp_valid[grant_id] = 1'b1;
        end
    end

    assign mul_start = (state == ISSUE);
    assign busy      = (state != IDLE);

    // Next-state logic. A done seen in WAIT wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mul_done || wd_expired) state_nxt = RESP;
            RESP:    if (resp_ready[grant_id]) state_nxt = resp_err ? IDLE : DRAIN;
            DRAIN:   if (!mul_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, operand latch, watchdog and result capture.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= '0;
            wd        <= '0;
            grant_id  <= '0;
            mul_mc    <= '0;
            mul_mp    <= '0;
            resp_prod <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        mul_mc   <= sel_mc;
                        mul_mp   <= sel_mp;
                        grant_id <= gnt;
                        rr       <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
                    end
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    wd <= wd + 1'b1;
                    if (mul_done) begin
                        resp_prod <= mul_prod;
                        resp_err  <= 1'b0;
                    end else if (wd_expired) begin
                        resp_prod <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_arbiter.sv
// tb_spm_arbiter: scoreboard bench for spm_arbiter with a behavioural multiplier core.
module tb_spm_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 128;
    localparam int TW      = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_mc;
    logic [32*NREQ-1:0]   req_mp;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [63:0]          resp_prod;
    logic                 resp_err;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic [31:0]          mul_mc;
    logic [31:0]          mul_mp;
    logic                 mul_start;
    logic [63:0]          mul_prod;
    logic                 mul_done;

    spm_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mc     (req_mc),
        .req_mp     (req_mp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_prod  (resp_prod),
        .resp_err   (resp_err),
        .busy       (busy),
        .grant_id   (grant_id),
        .mul_mc     (mul_mc),
        .mul_mp     (mul_mp),
        .mul_start  (mul_start),
        .mul_prod   (mul_prod),
        .mul_done   (mul_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] prod;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    exp_t mon_e;
    int   checks    = 0;
    int   failures  = 0;
    int   start_cnt = 0;
    int   resp_cnt  = 0;

    // Core model knobs.
    int   core_lat   = 8;
    int   core_hold  = 1;
    bit   core_hang  = 1'b0;
    bit   done_force = 1'b0;
    int   core_cnt   = 0;
    int   core_hcnt  = 0;
    logic core_done  = 1'b0;
    logic [63:0] core_prod = '0;

    assign mul_prod = core_prod;
    assign mul_done = core_done | done_force;

    function automatic logic [63:0] mul_ref(input logic [31:0] mc, input logic [31:0] mp);
        logic signed [63:0] a;
        logic signed [63:0] b;
        a = {{32{mc[31]}}, mc};
        b = {{32{mp[31]}}, mp};
        return a * b;
    endfunction

    // Behavioural core: done rises core_lat cycles after start, stays up core_hold cycles.
    always @(negedge clk) begin
        if (rst) begin
            core_cnt  = 0;
            core_hcnt = 0;
            core_done = 1'b0;
        end else if (mul_start) begin
            core_cnt  = core_lat;
            core_done = 1'b0;
            core_prod = mul_ref(mul_mc, mul_mp);
        end else if (core_cnt > 0) begin
            core_cnt = core_cnt - 1;
            if (core_cnt == 0 && !core_hang) begin
                core_done = 1'b1;
                core_hcnt = core_hold;
            end
        end else if (core_done) begin
            core_hcnt = core_hcnt - 1;
            if (core_hcnt <= 0) core_done = 1'b0;
        end
    end

    // Monitor: push expectations on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (mul_start) start_cnt++;
            checks++;
            if (!$onehot0(req_ready) || !$onehot0(resp_valid)) begin
                failures++;
                $display("FAIL onehot: req_ready=%b resp_valid=%b, required at most one bit each", req_ready, resp_valid);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_e.id   = i;
                    mon_e.err  = core_hang;
                    mon_e.prod = core_hang ? 64'd0 : mul_ref(req_mc[32*i +: 32], req_mp[32*i +: 32]);
                    exp_q.push_back(mon_e);
                    grant_log.push_back(i);
                end
                if (resp_valid[i] && resp_ready[i]) begin
                    resp_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL resp_unexpected: response to req %0d, required none", i);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (i != mon_e.id || resp_prod !== mon_e.prod || resp_err !== mon_e.err
                            || grant_id !== IDW'(mon_e.id)) begin
                            failures++;
                            $display("FAIL resp_data: got id=%0d gid=%0d prod=%h err=%b, required id=%0d prod=%h err=%b",
                                     i, grant_id, resp_prod, resp_err, mon_e.id, mon_e.prod, mon_e.err);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] mc, input logic [31:0] mp);
        req_mc[32*i +: 32] = mc;
        req_mp[32*i +: 32] = mp;
    endtask

    task automatic wait_grant(input int g0, input string name);
        int n = 0;
        while (grant_log.size() <= g0 && n < 500) begin
            tick();
            n++;
        end
        if (grant_log.size() <= g0) begin
            checks++;
            failures++;
            $display("FAIL %s_grant_timeout: no grant after %0d cycles, required a grant", name, n);
        end
    endtask

    task automatic wait_resp(input string name);
        int n = 0;
        while (resp_valid == '0 && n < 500) begin
            tick();
            n++;
        end
        if (resp_valid == '0) begin
            checks++;
            failures++;
            $display("FAIL %s_resp_timeout: no resp_valid after %0d cycles, required one", name, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (busy || exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_timeout: busy=%b pending=%0d, required idle and empty", name, busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        tick();
        tick();
        checks++;
        if ({req_ready, resp_valid, busy, grant_id, mul_start, resp_err} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b rvalid=%b busy=%b gid=%0d start=%b err=%b, required all 0",
                     req_ready, resp_valid, busy, grant_id, mul_start, resp_err);
        end
        checks++;
        if ({mul_mc, mul_mp, resp_prod} !== '0) begin
            failures++;
            $display("FAIL reset_data: mc=%h mp=%h prod=%h, required all 0", mul_mc, mul_mp, resp_prod);
        end
        req_valid = '0;
        rst       = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int s0 = start_cnt;
        int g0 = grant_log.size();
        set_req(2, 32'd3, 32'hFFFF_FFFB);
        req_valid = 4'b0100;
        wait_grant(g0, "single");
        req_valid = '0;
        wait_resp("single");
        checks++;
        if (resp_valid !== 4'b0100 || resp_prod !== 64'hFFFF_FFFF_FFFF_FFF1 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL single_resp: valid=%b prod=%h err=%b, required 0100 fffffffffffffff1 0",
                     resp_valid, resp_prod, resp_err);
        end
        wait_idle("single");
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL single_starts: %0d start pulses, required 1", start_cnt - s0);
        end
    endtask

    task automatic test_round_robin();
        int g0;
        int order[5] = '{0, 1, 2, 3, 0};
        int n = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'd100 + 32'(i * 7), 32'hFFFF_FFF0 - 32'(i * 3));
        g0 = grant_log.size();
        req_valid = '1;
        while (grant_log.size() < g0 + 5 && n < 1000) begin
            tick();
            n++;
        end
        req_valid = '0;
        wait_idle("rr");
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (grant_log.size() <= g0 + k) begin
                failures++;
                $display("FAIL rr_order[%0d]: no grant, required %0d", k, order[k]);
            end else if (grant_log[g0 + k] != order[k]) begin
                failures++;
                $display("FAIL rr_order[%0d]: got %0d, required %0d", k, grant_log[g0 + k], order[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int g0 = grant_log.size();
        int n  = 0;
        core_hang = 1'b1;
        set_req(3, 32'd9, 32'd9);
        req_valid = 4'b1000;
        wait_grant(g0, "timeout");
        req_valid = '0;
        while (!mul_start && n < 50) begin
            tick();
            n++;
        end
        tick();
        n = 0;
        while (!resp_err && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n != TIMEOUT) begin
            failures++;
            $display("FAIL timeout_cycles: resp_err after %0d WAIT cycles, required %0d", n, TIMEOUT);
        end
        checks++;
        if (resp_prod !== 64'd0 || resp_valid !== 4'b1000) begin
            failures++;
            $display("FAIL timeout_resp: prod=%h valid=%b, required 0 and 1000", resp_prod, resp_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_no_drain: busy=%b after error handshake, required 0", busy);
        end
        core_hang = 1'b0;
        wait_idle("timeout");
    endtask

    task automatic test_stall();
        int g0 = grant_log.size();
        int s0;
        int g1;
        int bad = 0;
        logic [NREQ-1:0] v0;
        logic [63:0]     p0;
        resp_ready = '0;
        set_req(1, 32'h1234_5678, 32'h8000_0000);
        req_valid = 4'b0010;
        wait_grant(g0, "stall");
        req_valid = '0;
        wait_resp("stall");
        v0 = resp_valid;
        p0 = resp_prod;
        s0 = start_cnt;
        g1 = grant_log.size();
        set_req(0, 32'd5, 32'd6);
        req_valid = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) req_valid = '0;
            tick();
            if (resp_valid !== v0 || resp_prod !== p0 || mul_start !== 1'b0 || req_ready !== '0) bad++;
        end
        checks++;
        if (bad != 0 || start_cnt != s0) begin
            failures++;
            $display("FAIL stall_hold: %0d unstable cycles, %0d new starts, required 0 and 0", bad, start_cnt - s0);
        end
        resp_ready = '1;
        wait_idle("stall");
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (grant_log.size() != g1) begin
            failures++;
            $display("FAIL stall_lost_req: %0d grants for dropped request, required 0", grant_log.size() - g1);
        end
    endtask

    task automatic test_drain();
        int s0 = start_cnt;
        int g0;
        int n = 0;
        int bad = 0;
        done_force = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        done_force = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || start_cnt != s0 || resp_valid !== '0) begin
            failures++;
            $display("FAIL idle_done: busy=%b starts=%0d rvalid=%b, required 0 0 0", busy, start_cnt - s0, resp_valid);
        end
        core_hold = 5;
        set_req(2, 32'd1000, 32'd2000);
        set_req(3, 32'hFFFF_FFFF, 32'd77);
        g0 = grant_log.size();
        req_valid = 4'b1100;
        while ((grant_log.size() < g0 + 2 || busy) && n < 1000) begin
            tick();
            n++;
            if (grant_log.size() >= g0 + 2) req_valid = '0;
            if (mul_start && mul_done) bad++;
        end
        req_valid = '0;
        wait_idle("drain");
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL drain_start: %0d starts issued with done high, required 0", bad);
        end
        checks++;
        if (grant_log.size() < g0 + 2 || grant_log[g0] != 2 || grant_log[g0 + 1] != 3) begin
            failures++;
            $display("FAIL drain_order: %0d grants logged, required 2 then 3", grant_log.size() - g0);
        end
        core_hold = 1;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_reset_midwait();
        int g0 = grant_log.size();
        int r0;
        int n = 0;
        core_lat = 70;
        set_req(1, 32'd12345, 32'hFFFF_0000);
        req_valid = 4'b0010;
        wait_grant(g0, "midwait");
        while (!mul_start && n < 50) begin
            tick();
            n++;
        end
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, busy, grant_id, mul_start, resp_err, mul_mc, mul_mp, resp_prod} !== '0) begin
            failures++;
            $display("FAIL midwait_reset: ready=%b rvalid=%b busy=%b gid=%0d start=%b mc=%h, required all 0",
                     req_ready, resp_valid, busy, grant_id, mul_start, mul_mc);
        end
        exp_q.delete();
        r0 = resp_cnt;
        tick();
        tick();
        rst = 1'b0;
        g0 = grant_log.size();
        wait_grant(g0, "midwait_regrant");
        req_valid = '0;
        checks++;
        if (grant_log.size() <= g0 || grant_log[g0] != 1) begin
            failures++;
            $display("FAIL midwait_regrant: grants=%0d, required re-grant of req 1", grant_log.size() - g0);
        end
        wait_idle("midwait");
        checks++;
        if (resp_cnt - r0 != 1) begin
            failures++;
            $display("FAIL midwait_resp_count: %0d responses, required 1", resp_cnt - r0);
        end
        core_lat = 8;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_mc     = '0;
        req_mp     = '0;
        resp_ready = '1;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stall();
        test_drain();
        test_reset_midwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
